wb_arbiter: RTL

Parametrised writeback arbiter between the execution pipes and the integer register file. Accepts results from `NCH` producer channels (integer pipes, load-store pipe, future muldiv/FPU-to-int) and routes up to `NWP` of them per cycle onto `NWP` register-file write ports. Fairness is round-robin rather than fixed priority. Retire-without-writeback is always acknowledged, and a registered retire counter is kept. Sits between the pipe writeback stages and `rf`; write ports are registered.

---
 rtl/wb_arbiter_pkg.sv | 14 +
 rtl/wb_arbiter_if.sv | 34 +++
 rtl/wb_rr_pick.sv | 29 ++
 rtl/wb_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared defaults and helpers for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int NCH_DEF  = 2;
    localparam int NWP_DEF  = 1;
    localparam int XLEN_DEF = 64;
    localparam int RAW_DEF  = 5;
    localparam int CNT_W    = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer channels in, register-file write ports out.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int NWP  = NWP_DEF,
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
);
    logic [NCH-1:0]      ch_valid;
    logic [NCH-1:0]      ch_wb_en;
    logic [NCH*RAW-1:0]  ch_dst;
    logic [NCH*XLEN-1:0] ch_result;
    logic [NCH*XLEN-1:0] ch_pc;
    logic [NCH-1:0]      ch_ready;
    logic [NWP-1:0]      rf_wen;
    logic [NWP*RAW-1:0]  rf_wdst;
    logic [NWP*XLEN-1:0] rf_wdata;
    logic [CNT_W-1:0]    retire_count;

    modport master (
        output ch_valid, ch_wb_en, ch_dst,
        output ch_result, ch_pc,
        input  ch_ready, rf_wen, rf_wdst,
        input  rf_wdata, retire_count
    );

    modport slave (
        input  ch_valid, ch_wb_en, ch_dst,
        input  ch_result, ch_pc,
        output ch_ready, rf_wen, rf_wdst,
        output rf_wdata, retire_count
    );
endinterface

// File: rtl/wb_rr_pick.sv
// Rotate-priority picker: first unmasked request at or after the pointer.
module wb_rr_pick
    import wb_arbiter_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int IW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [NCH-1:0] i_mask,
    input  logic [IW-1:0]  i_ptr,
    output logic [NCH-1:0] o_gnt,
    output logic [IW-1:0]  o_idx,
    output logic           o_vld
);
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            logic [IW-1:0] c;
            c = IW'((int'(i_ptr) + k) % NCH);
            if (!o_vld && i_req[c] && !i_mask[c]) begin
                o_vld    = 1'b1;
                o_gnt[c] = 1'b1;
                o_idx    = c;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NCH producers onto NWP registered RF ports.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int NWP  = NWP_DEF,
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int IW = idx_w(NCH);

    logic [IW-1:0]       r_rr_ptr;
    logic [NWP-1:0]      r_wen;
    logic [NWP*RAW-1:0]  r_wdst;
    logic [NWP*XLEN-1:0] r_wdata;
    logic [CNT_W-1:0]    r_retire_count;

    logic [NCH-1:0]      w_wreq;
    logic [NCH-1:0]      w_ret;
    logic [NCH-1:0]      w_gnt_all;
    logic [NCH-1:0]      w_ready;
    logic [NWP-1:0]      w_wen;
    logic [NWP*RAW-1:0]  w_wdst;
    logic [NWP*XLEN-1:0] w_wdata;
    logic [IW-1:0]       w_nptr;
    logic                w_any;
    logic [CNT_W-1:0]    w_xfer;
    logic                w_unused_pc;

    // x0 writes are demoted to retire-only
    always_comb begin
        w_wreq = '0;
        w_ret  = '0;
        for (int i = 0; i < NCH; i++) begin
            w_wreq[i] = bus.ch_valid[i] && bus.ch_wb_en[i]
                        && (bus.ch_dst[i*RAW +: RAW] != '0);
            w_ret[i]  = bus.ch_valid[i] && !w_wreq[i];
        end
    end

    for (genvar p = 0; p < NWP; p++) begin : g_st
        logic [NCH-1:0]  w_mask_in;
        logic [NCH-1:0]  w_gacc_in;
        logic [NCH-1:0]  w_gacc_out;
        logic [NCH-1:0]  w_gnt;
        logic [IW-1:0]   w_ptr_in;
        logic [IW-1:0]   w_ptr_out;
        logic [IW-1:0]   w_idx;
        logic            w_any_in;
        logic            w_any_out;
        logic            w_vld;
        logic [RAW-1:0]  w_gdst;
        logic [XLEN-1:0] w_gdata;

        if (p == 0) begin : g_first
            assign w_mask_in = '0;
            assign w_gacc_in = '0;
            assign w_ptr_in  = r_rr_ptr;
            assign w_any_in  = 1'b0;
        end else begin : g_next
            // mask earlier grants and anything sharing their dst
            always_comb begin
                w_mask_in = g_st[p-1].w_mask_in
                          | g_st[p-1].w_gnt;
                for (int i = 0; i < NCH; i++) begin
                    if (g_st[p-1].w_vld &&
                        bus.ch_dst[i*RAW +: RAW]
                          == g_st[p-1].w_gdst)
                        w_mask_in[i] = 1'b1;
                end
            end
            assign w_gacc_in = g_st[p-1].w_gacc_out;
            assign w_ptr_in  = g_st[p-1].w_ptr_out;
            assign w_any_in  = g_st[p-1].w_any_out;
        end

        wb_rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
            .i_req  (w_wreq),
            .i_mask (w_mask_in),
            .i_ptr  (r_rr_ptr),
            .o_gnt  (w_gnt),
            .o_idx  (w_idx),
            .o_vld  (w_vld)
        );

        assign w_gdst  = bus.ch_dst[int'(w_idx)*RAW +: RAW];
        assign w_gdata = bus.ch_result[int'(w_idx)*XLEN +: XLEN];

        assign w_gacc_out = w_gacc_in | w_gnt;
        assign w_any_out  = w_any_in | w_vld;
        assign w_ptr_out  = !w_vld ? w_ptr_in :
                            (int'(w_idx) == NCH-1) ? '0 :
                            w_idx + 1'b1;

        assign w_wen[p]               = w_vld;
        assign w_wdst[p*RAW +: RAW]   = w_vld ? w_gdst : '0;
        assign w_wdata[p*XLEN +: XLEN] = w_vld ? w_gdata : '0;
    end

    assign w_gnt_all = g_st[NWP-1].w_gacc_out;
    assign w_any     = g_st[NWP-1].w_any_out;
    assign w_nptr    = g_st[NWP-1].w_ptr_out;
    assign w_ready   = w_ret | w_gnt_all;

    always_comb begin
        w_xfer = '0;
        for (int i = 0; i < NCH; i++)
            w_xfer = w_xfer
                   + CNT_W'(bus.ch_valid[i] & w_ready[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= '0;
            r_wen          <= '0;
            r_wdst         <= '0;
            r_wdata        <= '0;
            r_retire_count <= '0;
        end else begin
            if (w_any)
                r_rr_ptr <= w_nptr;
            r_wen          <= w_wen;
            r_wdst         <= w_wdst;
            r_wdata        <= w_wdata;
            r_retire_count <= r_retire_count + w_xfer;
        end
    end

    assign w_unused_pc      = ^bus.ch_pc;
    assign bus.ch_ready     = w_ready;
    assign bus.rf_wen       = r_wen;
    assign bus.rf_wdst      = r_wdst;
    assign bus.rf_wdata     = r_wdata;
    assign bus.retire_count = r_retire_count;
endmodule
